// File: rtl/led_pkg.sv
// Shared definitions for the HUB75-style LED panel scan controller.
package led_pkg;

    // Default panel geometry and lit time per row
    localparam int COLS_DEF    = 64;
    localparam int ROWS_DEF    = 32;
    localparam int ON_TIME_DEF = 64;

    // Counter widths: column, row and dwell
    localparam int COL_W   = 6;
    localparam int ROW_W   = 5;
    localparam int DWELL_W = 16;

    // Scan sequence for one row: shift pixels, blank, latch, light
    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        BLANK = 2'd1,
        LATCH = 2'd2,
        DWELL = 2'd3
    } led_state_t;

endpackage

// File: rtl/led_controller.sv
// LED panel scan controller: shifts one row of column data out with
// display_clk, blanks the panel, latches the row, then lights it for
// ON_TIME cycles before moving on to the next row.
module led_controller
    import led_pkg::*;
#(
    parameter int COLS    = COLS_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int ON_TIME = ON_TIME_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [ROW_W-1:0] row_addr,
    output logic [COL_W-1:0] col_addr,
    output logic             oe,
    output logic             latch,
    output logic             display_clk
);

    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(ON_TIME - 1);

    led_state_t         r_state;
    logic [COL_W-1:0]   r_col;
    logic               r_phase;
    logic [ROW_W-1:0]   r_row;
    logic [DWELL_W-1:0] r_dwell;

    logic [ROW_W-1:0]   r_row_addr;
    logic [COL_W-1:0]   r_col_addr;
    logic               r_oe;
    logic               r_latch;
    logic               r_display_clk;

    // Scan FSM: each edge drives the outputs for the current step and
    // advances the column/phase, row and dwell counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= SHIFT;
            r_col         <= '0;
            r_phase       <= 1'b0;
            r_row         <= '0;
            r_dwell       <= '0;
            r_row_addr    <= '0;
            r_col_addr    <= '0;
            r_oe          <= 1'b1;
            r_latch       <= 1'b0;
            r_display_clk <= 1'b0;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_col_addr    <= r_col;
                    r_display_clk <= r_phase;
                    r_latch       <= 1'b0;
                    r_phase       <= ~r_phase;
                    if (r_phase) begin
                        if (r_col == LAST_COL) begin
                            r_col   <= '0;
                            r_state <= BLANK;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                BLANK: begin
                    r_oe          <= 1'b1;
                    r_display_clk <= 1'b0;
                    r_latch       <= 1'b0;
                    r_row_addr    <= r_row;
                    r_state       <= LATCH;
                end
                LATCH: begin
                    r_oe          <= 1'b1;
                    r_display_clk <= 1'b0;
                    r_latch       <= 1'b1;
                    r_dwell       <= '0;
                    r_state       <= DWELL;
                end
                DWELL: begin
                    r_oe          <= 1'b0;
                    r_display_clk <= 1'b0;
                    r_latch       <= 1'b0;
                    if (r_dwell == LAST_DWELL) begin
                        r_dwell <= '0;
                        r_col   <= '0;
                        r_phase <= 1'b0;
                        r_row   <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
                        r_state <= SHIFT;
                    end else begin
                        r_dwell <= r_dwell + DWELL_W'(1);
                    end
                end
                default: begin
                    r_state <= SHIFT;
                end
            endcase
        end
    end

    assign row_addr    = r_row_addr;
    assign col_addr    = r_col_addr;
    assign oe          = r_oe;
    assign latch       = r_latch;
    assign display_clk = r_display_clk;

endmodule

// File: tb/tb_led_controller.sv
// Directed self-checking bench for led_controller with default geometry.
// Cycle n is the output sample taken on the falling edge after the n-th
// rising edge following reset release (n counts from 0).
module tb_led_controller;

    localparam int COLS       = 64;
    localparam int ROWS       = 32;
    localparam int ON_TIME    = 64;
    localparam int ROW_PERIOD = 2 * COLS + 2 + ON_TIME;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] row_addr;
    logic [5:0] col_addr;
    logic       oe;
    logic       latch;
    logic       display_clk;

    int checks = 0;
    int errors = 0;

    led_controller #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .ON_TIME (ON_TIME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .oe          (oe),
        .latch       (latch),
        .display_clk (display_clk)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive reset on a falling edge, then let some cycles pass
    task automatic applyStimulus(input logic rstValue, input int cycles);
        @(negedge clk);
        rst = rstValue;
        repeat (cycles) @(negedge clk);
    endtask

    // Directed scenario: reset, first row, full frame wrap, mid-row reset
    initial begin
        int         nRise;
        int         nLatch;
        int         lastLatch;
        int         nRowChange;
        logic       prevDclk;
        logic       prevLatch;
        logic       prevOe;
        logic [4:0] prevRow;
        logic [4:0] expRow;
        logic       sawLatch;

        rst = 1'b0;
        #47;
        checkOutput("reset_row_addr", row_addr, 0);
        checkOutput("reset_col_addr", col_addr, 0);
        checkOutput("reset_oe", oe, 1);
        checkOutput("reset_latch", latch, 0);
        checkOutput("reset_display_clk", display_clk, 0);

        applyStimulus(1'b1, 0);

        nRise      = 0;
        nLatch     = 0;
        lastLatch  = 0;
        nRowChange = 0;
        prevDclk   = 1'b0;
        prevLatch  = 1'b0;
        prevOe     = 1'b1;
        prevRow    = 5'd0;

        for (int n = 0; n < 6400; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checkOutput("cyc0_display_clk", display_clk, 0);
                checkOutput("cyc0_col_addr", col_addr, 0);
                checkOutput("cyc0_row_addr", row_addr, 0);
                checkOutput("cyc0_oe", oe, 1);
            end
            if (display_clk && !prevDclk && nLatch == 0) begin
                checkOutput("shift_col_at_rise", col_addr, nRise);
                nRise++;
            end
            if (latch) begin
                if (nLatch == 0) begin
                    checkOutput("first_latch_cycle", n, 129);
                    checkOutput("rises_before_latch", nRise, COLS);
                    checkOutput("latch_oe", oe, 1);
                    checkOutput("pre_latch_oe", prevOe, 1);
                end else begin
                    checkOutput("latch_period", n - lastLatch, ROW_PERIOD);
                end
                lastLatch = n;
                nLatch++;
            end
            if (prevLatch) begin
                checkOutput("latch_width", latch, 0);
            end
            if (n >= 130 && n <= 193) begin
                checkOutput("dwell_oe", oe, 0);
                checkOutput("dwell_display_clk", display_clk, 0);
            end
            if (n == 194) begin
                checkOutput("shift_oe_held_low", oe, 0);
                checkOutput("shift_restart_col", col_addr, 0);
            end
            if (row_addr != prevRow) begin
                expRow = prevRow + 5'd1;
                checkOutput("row_step", row_addr, expRow);
                checkOutput("row_change_oe", oe, 1);
                nRowChange++;
            end
            prevDclk  = display_clk;
            prevLatch = latch;
            prevOe    = oe;
            prevRow   = row_addr;
        end
        checkOutput("row_change_count", nRowChange, ROWS);
        checkOutput("row_wrapped_to_0", row_addr, 0);
        checkOutput("latch_count", nLatch, 33);

        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 0);
        for (int n = 0; n <= 5 * ROW_PERIOD + 40; n++) begin
            @(negedge clk);
        end
        checkOutput("pre_reset_col_addr", col_addr, 20);
        checkOutput("pre_reset_row_addr", row_addr, 4);
        checkOutput("pre_reset_oe", oe, 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_row_addr", row_addr, 0);
        checkOutput("async_col_addr", col_addr, 0);
        checkOutput("async_oe", oe, 1);
        checkOutput("async_latch", latch, 0);
        checkOutput("async_display_clk", display_clk, 0);

        repeat (5) @(negedge clk);
        rst = 1'b1;
        sawLatch = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (latch && !sawLatch) begin
                sawLatch = 1'b1;
                checkOutput("restart_latch_cycle", n, 129);
                checkOutput("restart_row_addr", row_addr, 0);
            end
        end
        checkOutput("restart_latch_seen", sawLatch, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
